uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer between NUM_REQ byte producers, e.g. a debug printer, an echo path from uart_rx and a status reporter.
- Accepts bytes on per-requester valid/ready handshakes and selects one requester at a time by round-robin.
- Sequences the serializer through its start/complete handshake.
- Holds a message lock, so a multi-byte message from one requester is never interleaved with bytes from another.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- ID_W, 3: width of grant_id; must be at least clog2(NUM_REQ).

Ports:
- clk  in  1  system clock, 100 MHz; every block register updates on posedge.
- rst_n  in  1  synchronous reset, active low.
- req_valid  in  NUM_REQ  bit i set: requester i presents a byte.
- req_data  in  8*NUM_REQ  byte of requester i on bits [8i+7:8i].
- req_last  in  NUM_REQ  bit i set: the presented byte is the last byte of its message.
- req_ready  out  NUM_REQ  bit i set: the byte of requester i is accepted this cycle (one-hot or zero).
- tx_start  out  1  to uart_tx start.
- tx_data  out  8  to uart_tx input_data; stable from acceptance until tx_complete rises again.
- tx_complete  in  1  from uart_tx complete (high = serializer idle).
- grant_id  out  ID_W  index of the requester currently being served or locked.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n=0 at a posedge): state=IDLE, rr_ptr=0, lock=0, tx_start=0, tx_data=0, req_ready=0, grant_id=0, busy=0. Reset mid-byte does not abort the serializer.
- IDLE: grants only when tx_complete=1 and some req_valid bit is set.
  - Winner is the first set req_valid bit searched circularly from rr_ptr.
  - In the grant cycle, req_ready[winner]=1 combinationally; the byte is accepted when valid and ready are both high.
  - Next edge: tx_data<=byte, grant_id<=winner, lock<=~req_last[winner], state<=START.
- START: tx_start=1. When tx_complete=0 is sampled, state<=WAIT; tx_start drops in WAIT.
- WAIT: when tx_complete=1 is sampled:
  - If lock=1, state<=HOLD.
  - Otherwise rr_ptr<=(grant_id+1) mod NUM_REQ and state<=IDLE.
- HOLD: only requester grant_id is eligible; all other requests wait.
  - If req_valid[grant_id]=1, accept as in IDLE, set lock<=~req_last, state<=START.
  - HOLD has no timeout; a stalled locked requester blocks all others.
- req_ready is zero in START and WAIT, so no data is accepted while a byte is in flight.
- Latency: valid-to-accept is 0 cycles in IDLE/HOLD when the request wins. Accept-to-tx_start is 1 cycle.
- Simultaneous requests resolve by round-robin. A requester that drops req_valid before acceptance loses nothing; the byte was never taken.
- A req_valid bit at or above NUM_REQ is ignored (generic port width).
- Throughput: each byte costs one uart_tx frame plus at most 3 cycles of handshake.

Optional Feature:
- Macro: UART_ARB_FIXED_PRIO_EN.
- Defined: IDLE selects the lowest-index valid requester (index 0 highest priority), and rr_ptr is not updated. Message lock and HOLD behave unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- Single request: req_valid=0001, data 0x41, last=1 -> one-cycle req_ready[0], tx_start next cycle, uart_tx line shows 0x41 LSB first, busy falls after tx_complete returns, rr_ptr=1.
- Round-robin: all four valid with last=1, data 0x10..0x13, held valid until accepted -> serial order 0x10,0x11,0x12,0x13, then 0x10 again; under UART_ARB_FIXED_PRIO_EN, requester 0 is always granted while valid.
- Message lock: req0 sends "ab" (last only on 'b') while req1 sends "Z" -> serial order a,b,Z; req_ready[1] stays 0 until 'b' completes.
- Stalled lock: req0 sends 'a' with last=0, then drops valid for 5000 cycles while req2 is valid -> arbiter stays in HOLD with grant_id=0; req0 then sends 'b' last=1 -> 'b' sent, then req2's byte.
- Reset mid-frame: assert rst_n=0 for 1 cycle during WAIT while uart_tx shifts 0x55 -> outputs reset to 0; a pending req1 is not granted until tx_complete=1; 0x55 frame finishes intact.
- Back-to-back: req3 holds valid continuously with 10 bytes, last on the 10th -> 10 contiguous frames, at most 3 idle clk between stop bit and next start bit.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one uart_tx serializer between NUM_REQ byte producers. One requester
// is served at a time. A requester whose byte is not flagged "last" keeps the
// serializer locked until it delivers its last byte, so messages are never
// interleaved.
//
// Optional build macro:
//   UART_ARB_FIXED_PRIO_EN  when defined, IDLE grants the lowest-index valid
//                           requester (index 0 highest priority) and no
//                           round-robin pointer is kept. Lock/HOLD unchanged.
//                           When undefined, IDLE grants round-robin.
//
// Ports:
//   clk          system clock, all registers update on posedge
//   rst_n        synchronous reset, active low
//   req_valid    per-requester byte valid
//   req_data     per-requester byte, requester i on [8i+7:8i]
//   req_last     per-requester "last byte of message" flag
//   req_ready    per-requester accept strobe (one-hot or zero)
//   tx_start     start strobe to uart_tx, held until uart_tx goes busy
//   tx_data      byte to uart_tx, stable from acceptance to next completion
//   tx_complete  uart_tx idle flag (high = idle)
//   grant_id     index of the requester being served or holding the lock
//   busy         high in every state except IDLE
//
// Handshake: a byte from requester i is transferred on a posedge where
// req_valid[i] and req_ready[i] are both high. req_ready is combinational,
// is never high in START or WAIT, and never depends on req_ready itself.
// A requester may drop req_valid before acceptance without losing anything.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_complete,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t          state;
  logic            lock;
`ifndef UART_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0] rr_ptr;
`endif

  // ---------------------------------------------------------------------------
  // Winner search for IDLE.
  // ---------------------------------------------------------------------------
  logic            win_found;
  logic [ID_W-1:0] win_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
`ifdef UART_ARB_FIXED_PRIO_EN
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!win_found && req_valid[j]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(j);
      end
    end
`else
    // Circular search from rr_ptr as two linear passes: first the indices at
    // or above the pointer, then wrap around to the lower ones.
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!win_found && req_valid[j] && (ID_W'(j) >= rr_ptr)) begin
        win_found = 1'b1;
        win_idx   = ID_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!win_found && req_valid[j]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(j);
      end
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Selected requester: the locked one in HOLD, the search winner otherwise.
  // ---------------------------------------------------------------------------
  logic [ID_W-1:0] sel_idx;
  logic            sel_valid;
  logic [7:0]      sel_data;
  logic            sel_last;
  logic            accept;

  always_comb begin
    sel_idx   = (state == ST_HOLD) ? grant_id : win_idx;
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_last  = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (sel_idx == ID_W'(j)) begin
        sel_valid = req_valid[j];
        sel_data  = req_data[8*j +: 8];
        sel_last  = req_last[j];
      end
    end

    // In IDLE the serializer must also be idle; HOLD is only entered after
    // completion was seen, so it needs no extra qualifier. Nothing is
    // accepted while reset is asserted.
    case (state)
      ST_IDLE: accept = rst_n && tx_complete && win_found;
      ST_HOLD: accept = rst_n && sel_valid;
      default: accept = 1'b0;
    endcase

    for (int j = 0; j < NUM_REQ; j++) begin
      req_ready[j] = accept && (sel_idx == ID_W'(j));
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      lock     <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
`ifndef UART_ARB_FIXED_PRIO_EN
      rr_ptr   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            tx_data  <= sel_data;
            grant_id <= sel_idx;
            lock     <= ~sel_last;
            tx_start <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_START;
          end
        end

        ST_START: begin
          // uart_tx has taken the byte once it reports busy.
          if (!tx_complete) begin
            tx_start <= 1'b0;
            state    <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (tx_complete) begin
            if (lock) begin
              state <= ST_HOLD;
            end else begin
`ifdef UART_ARB_FIXED_PRIO_EN
              // Fixed priority keeps no rotation state.
`else
              rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
`endif
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Bench for uart_tx_arbiter with NUM_REQ=4. Per-requester source queues feed
// the request ports; a behavioural uart_tx model takes bytes on tx_start and
// holds tx_complete low for FRAME cycles. Every byte the model takes is
// compared against the expected queue filled by the stimulus process.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int NR    = 4;
  localparam int IW    = 3;
  localparam int FRAME = 20;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_complete;
  logic [IW-1:0]   grant_id;
  logic            busy;

  uart_tx_arbiter #(.NUM_REQ(NR), .ID_W(IW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_complete (tx_complete),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [IW+7:0] exp_q[$];        // {grant_id, byte} in serial order
  logic [8:0]    src_q[NR][$];    // {last, byte} per requester
  int            n_cmp = 0;
  int            n_bad = 0;

  logic [NR-1:0] take;            // handshakes due at the coming posedge
  int            cycle = 0;
  int            done_cycle = 0;
  int            cnt = 0;
  logic [7:0]    cur_byte;
  bit            frame_rst = 1'b0;
  bit            b2b_mode = 1'b0;
  int            b2b_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit src_empty();
    bit e = 1'b1;
    for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: present queue heads on the negedge, pop after a handshake.
  // ---------------------------------------------------------------------------
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    take      = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (take[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      end
      for (int i = 0; i < NR; i++) begin
        if (src_q[i].size() > 0) begin
          req_valid[i]      = 1'b1;
          req_data[8*i +: 8] = src_q[i][0][7:0];
          req_last[i]       = src_q[i][0][8];
        end else begin
          req_valid[i]      = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]       = 1'b0;
        end
      end
      #1;
      take = req_valid & req_ready;
      check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
    end
  end

  // ---------------------------------------------------------------------------
  // uart_tx model and monitor
  // ---------------------------------------------------------------------------
  initial begin
    logic [IW+7:0] e;
    tx_complete = 1'b1;
    forever begin
      @(negedge clk);
      cycle++;
      if (|take) check("start_latency", 32'(tx_start), 32'd1);
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          if (!frame_rst) check("tx_data_stable", 32'(tx_data), 32'(cur_byte));
          tx_complete = 1'b1;
          done_cycle  = cycle;
        end
      end else if (tx_start && tx_complete) begin
        cur_byte    = tx_data;
        tx_complete = 1'b0;
        cnt         = FRAME;
        frame_rst   = 1'b0;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_byte: got id %0d data 0x%0h, expected no byte (t=%0t)",
                   grant_id, tx_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", 32'({grant_id, tx_data}), 32'(e));
        end
        if (b2b_mode) begin
          if (b2b_n > 0) check("b2b_gap_le3", 32'((cycle - done_cycle) <= 3), 32'd1);
          b2b_n++;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic push_src(input int r, input logic [7:0] d, input logic l);
    src_q[r].push_back({l, d});
  endtask

  task automatic push_exp(input int id, input logic [7:0] d);
    exp_q.push_back({IW'(id), d});
  endtask

  // Wait for all bytes sent and the serializer idle; optionally also busy=0.
  task automatic wait_done(input string name, input int budget, input bit need_idle);
    int n = 0;
    while (n < budget && !(src_empty() && exp_q.size() == 0 && cnt == 0 &&
                           tx_complete && (!need_idle || !busy))) begin
      @(negedge clk);
      #2;
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_capture(input string name, input int budget);
    int n = 0;
    while (n < budget && exp_q.size() != 0) begin
      @(negedge clk);
      #2;
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    bit ready_seen;
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request from requester 0. Afterwards rr_ptr=1.
    push_exp(0, 8'h41);
    push_src(0, 8'h41, 1'b1);
    wait_done("t1_done", 500, 1'b1);
    check("t1_busy_low", 32'(busy), 32'd0);
    check("t1_tx_start_low", 32'(tx_start), 32'd0);

    // All four valid; requester 0 has a second byte. rr_ptr starts at 1.
`ifdef UART_ARB_FIXED_PRIO_EN
    push_exp(0, 8'h10); push_exp(0, 8'h14);
    push_exp(1, 8'h11); push_exp(2, 8'h12); push_exp(3, 8'h13);
`else
    push_exp(1, 8'h11); push_exp(2, 8'h12); push_exp(3, 8'h13);
    push_exp(0, 8'h10); push_exp(0, 8'h14);
`endif
    push_src(0, 8'h10, 1'b1); push_src(0, 8'h14, 1'b1);
    push_src(1, 8'h11, 1'b1); push_src(2, 8'h12, 1'b1); push_src(3, 8'h13, 1'b1);
    wait_done("t2_done", 2000, 1'b1);

    // Message lock: requester 1 sends "ab", requester 2 sends "Z" meanwhile.
    // rr_ptr=1, so requester 1 wins first and must keep the line to 'b'.
    push_exp(1, 8'h61); push_exp(1, 8'h62); push_exp(2, 8'h5A);
    push_src(1, 8'h61, 1'b0); push_src(1, 8'h62, 1'b1);
    push_src(2, 8'h5A, 1'b1);
    wait_done("t3_done", 2000, 1'b1);

    // Stalled lock: requester 0 sends 'a' without last, then goes quiet while
    // requester 2 waits. rr_ptr=3 before, wraps to requester 0.
    push_exp(0, 8'h61);
    push_src(0, 8'h61, 1'b0);
    wait_done("t4_a_done", 500, 1'b0);
    push_src(2, 8'h63, 1'b1);
    repeat (5000) @(negedge clk);
    #2;
    check("t4_hold_grant_id", 32'(grant_id), 32'd0);
    check("t4_hold_busy", 32'(busy), 32'd1);
    check("t4_hold_no_ready", 32'(req_ready), 32'd0);
    push_exp(0, 8'h62); push_exp(2, 8'h63);
    push_src(0, 8'h62, 1'b1);
    wait_done("t4_done", 2000, 1'b1);

    // Reset during WAIT while 0x55 from requester 2 is on the line.
    push_exp(2, 8'h55);
    push_src(2, 8'h55, 1'b1);
    wait_capture("t5_capture", 500);
    push_src(1, 8'h5A, 1'b1);
    push_src(3, 8'h5B, 1'b1);
    frame_rst = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t5_rst_tx_start", 32'(tx_start), 32'd0);
    check("t5_rst_tx_data", 32'(tx_data), 32'd0);
    check("t5_rst_grant_id", 32'(grant_id), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_req_ready", 32'(req_ready), 32'd0);
    check("t5_frame_still_running", 32'(tx_complete), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // rr_ptr is back to 0, so requester 1 goes before requester 3.
    push_exp(1, 8'h5A); push_exp(3, 8'h5B);
    ready_seen = 1'b0;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      #2;
      if (tx_complete) break;
      if (req_ready != '0) ready_seen = 1'b1;
      n++;
    end
    check("t5_no_grant_while_busy", 32'(ready_seen), 32'd0);
    wait_done("t5_done", 2000, 1'b1);

    // Back-to-back message of 10 bytes from requester 3.
    b2b_mode = 1'b1;
    b2b_n = 0;
    for (int k = 0; k < 10; k++) begin
      push_exp(3, 8'h30 + 8'(k));
      push_src(3, 8'h30 + 8'(k), (k == 9));
    end
    wait_done("t6_done", 2000, 1'b1);
    b2b_mode = 1'b0;
    check("t6_byte_count", 32'(b2b_n), 32'd10);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
